// File: rtl/fround_pipe.sv
// -----------------------------------------------------------------------------
// fround_pipe
//   Pipelined float-to-integral-value rounding unit. Takes an IEEE-style float
//   (sign | EXP_W exponent | MAN_W mantissa) and returns a float of the same
//   format whose value is integral. The rounding mode is chosen per op:
//   RNE, toward zero, floor or ceil. An opaque tag travels with each op, and an
//   inexact flag reports when the result differs from the source.
//
//   The rounding is computed combinationally from the input. The result then
//   moves through LATENCY register stages. All stages share a single advance
//   enable, so the pipeline moves forward or holds as a single unit.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset; drops every in-flight op
//   in_valid    op present on in_*
//   in_ready    unit accepts an op this cycle (combinational)
//   in_data     source float, W = 1+EXP_W+MAN_W bits
//   in_mode     00 RNE, 01 toward zero, 10 floor, 11 ceil
//   in_tag      opaque id, returned unchanged with the result
//   out_valid   result present on out_*
//   out_ready   consumer takes the result this cycle
//   out_data    rounded float
//   out_tag     tag of this result
//   out_inexact result differs from source (NaN/inf/zero never inexact)
// -----------------------------------------------------------------------------
module fround_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_data,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_inexact
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EM_W = EXP_W + MAN_W;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic [EM_W-1:0] EM_ONE = EM_W'(1);

  typedef enum logic [1:0] {
    RM_RNE   = 2'b00,
    RM_RTZ   = 2'b01,
    RM_FLOOR = 2'b10,
    RM_CEIL  = 2'b11
  } rmode_e;

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("fround_pipe: LATENCY must be in 1..3");
  end

  // ---------------------------------------------------------------------------
  // Rounding datapath (combinational)
  // ---------------------------------------------------------------------------
  rmode_e          mode;
  logic            sgn;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man;
  logic [EM_W-1:0] em;          // exponent|mantissa without sign
  logic [EM_W-1:0] lsb_unit;    // weight of the integer LSB inside em
  logic [EM_W-1:0] frac_mask;
  logic [EM_W-1:0] frac;
  logic [EM_W-1:0] half;
  logic            int_lsb;
  logic            up;
  int              sh;          // number of fraction bits, 1..MAN_W
  logic [W-1:0]    res_d;
  logic            inexact_d;

  assign mode  = rmode_e'(in_mode);
  assign sgn   = in_data[W-1];
  assign exp_f = in_data[W-2:MAN_W];
  assign man   = in_data[MAN_W-1:0];
  assign em    = in_data[EM_W-1:0];

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    res_d     = in_data;
    inexact_d = 1'b0;
    up        = 1'b0;
    sh        = 0;
    lsb_unit  = '0;
    frac_mask = '0;
    frac      = '0;
    half      = '0;
    int_lsb   = 1'b0;

    if (exp_f == '1) begin
      // Inf passes through; NaN keeps its payload but is made quiet.
      if (man != '0) res_d[MAN_W-1] = 1'b1;
    end else if (exp_f == '0) begin
      // Zero and subnormals are flushed to a signed zero.
      res_d = {sgn, {EM_W{1'b0}}};
    end else if (int'(exp_f) >= BIAS + MAN_W) begin
      // There are no fraction bits left, so the value is already integral.
      res_d = in_data;
    end else if (int'(exp_f) < BIAS) begin
      // 0 < |x| < 1: the result is either signed zero or signed one.
      inexact_d = 1'b1;
      unique case (mode)
        RM_RNE:   up = (int'(exp_f) == BIAS - 1) && (man != '0);  // |x| > 0.5
        RM_RTZ:   up = 1'b0;
        RM_FLOOR: up = sgn;
        RM_CEIL:  up = ~sgn;
      endcase
      res_d = up ? {sgn, EXP_W'(BIAS), {MAN_W{1'b0}}} : {sgn, {EM_W{1'b0}}};
    end else begin
      sh        = MAN_W + BIAS - int'(exp_f);
      lsb_unit  = EM_ONE << sh;
      frac_mask = lsb_unit - EM_ONE;
      frac      = em & frac_mask;
      half      = lsb_unit >> 1;
      // When u = 0 the integer LSB is the hidden bit, which is always 1.
      int_lsb   = (sh == MAN_W) ? 1'b1 : |(em & lsb_unit);
      unique case (mode)
        RM_RNE:   up = (frac > half) || ((frac == half) && int_lsb);
        RM_RTZ:   up = 1'b0;
        RM_FLOOR: up = sgn  && (frac != '0);
        RM_CEIL:  up = ~sgn && (frac != '0);
      endcase
      inexact_d = (frac != '0);
      // The increment is added across exponent|mantissa, so a mantissa
      // overflow carries straight into the exponent.
      res_d = {sgn, (em & ~frac_mask) + (up ? lsb_unit : '0)};
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline stages sharing one advance enable
  // ---------------------------------------------------------------------------
  logic             valid_q   [LATENCY];
  logic [W-1:0]     data_q    [LATENCY];
  logic [TAG_W-1:0] tag_q     [LATENCY];
  logic             inexact_q [LATENCY];
  logic             adv;

  assign adv      = ~valid_q[LATENCY-1] | out_ready;
  assign in_ready = adv;

  // NOTE: state uses non-blocking assignments, so every stage samples the value
  // its predecessor held before the clock edge.
  // NOTE: these stage registers are few and small, and the outputs must be zero
  // in reset, so the whole array is reset and not only the valid bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i]   <= 1'b0;
        data_q[i]    <= '0;
        tag_q[i]     <= '0;
        inexact_q[i] <= 1'b0;
      end
    end else if (adv) begin
      valid_q[0]   <= in_valid;
      data_q[0]    <= res_d;
      tag_q[0]     <= in_tag;
      inexact_q[0] <= inexact_d;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i]   <= valid_q[i-1];
        data_q[i]    <= data_q[i-1];
        tag_q[i]     <= tag_q[i-1];
        inexact_q[i] <= inexact_q[i-1];
      end
    end
  end

  assign out_valid   = valid_q[LATENCY-1];
  assign out_data    = data_q[LATENCY-1];
  assign out_tag     = tag_q[LATENCY-1];
  assign out_inexact = inexact_q[LATENCY-1];

endmodule
